// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 mux for WIDTH-bit channels built from registered radix-4 stages,
// with valid/ready handshake, per-beat captured select and an auto-scan pointer.
module mux_tree_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned N     = 8,
   localparam int unsigned SELW   = $clog2(N),
   localparam int unsigned STAGES = (N <= 4) ? 1 : ((N <= 16) ? 2 : 3)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic                 scan_clr,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_ch,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int unsigned PADN = 4 ** STAGES;

   logic                 stall;
   logic                 accept;
   logic [SELW-1:0]      scan_d, scan_q;
   logic [SELW:0]        sel_ext;
   logic [SELW-1:0]      ch_acc;
   logic [PADN*WIDTH-1:0] in_flat;
   logic [WIDTH-1:0]     in_pad [PADN];

   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;
   assign accept   = in_valid && in_ready;

   // Out-of-range manual selects clamp to the last real channel.
   assign sel_ext = {1'b0, sel};
   assign ch_acc  = mode ? scan_q :
                    ((sel_ext >= (SELW+1)'(N)) ? SELW'(N - 1) : sel);

   // Pad to a full radix-4 tree; padded channels are zero and never selected.
   assign in_flat = (PADN*WIDTH)'(in_data);
   always_comb begin
      for (int k = 0; k < PADN; k++) begin
         in_pad[k] = in_flat[k*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      scan_d = scan_q;
      if (scan_clr) begin
         scan_d = '0;
      end else if (accept && mode) begin
         scan_d = (scan_q == SELW'(N - 1)) ? '0 : scan_q + SELW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_q <= '0;
      end else begin
         scan_q <= scan_d;
      end
   end

   for (genvar s = 0; s < STAGES; s++) begin : g_st
      localparam int unsigned NODES = 4 ** (STAGES - 1 - s);
      localparam int unsigned IW    = $clog2(4 * NODES);

      logic [WIDTH-1:0] src [4*NODES];
      logic             src_valid;
      logic [SELW-1:0]  src_ch;
      logic [1:0]       idx;
      logic [IW-1:0]    pos;
      logic [WIDTH-1:0] data_d [NODES];
      logic [WIDTH-1:0] data_q [NODES];
      logic             valid_d, valid_q;
      logic [SELW-1:0]  ch_d, ch_q;

      if (s == 0) begin : g_head
         assign src       = in_pad;
         assign src_valid = in_valid;
         assign src_ch    = ch_acc;
      end else begin : g_body
         assign src       = g_st[s-1].data_q;
         assign src_valid = g_st[s-1].valid_q;
         assign src_ch    = g_st[s-1].ch_q;
      end

      // Each stage consumes the next two select bits of the carried tag.
      assign idx = 2'(src_ch >> (2 * s));

      always_comb begin
         valid_d = valid_q;
         ch_d    = ch_q;
         data_d  = data_q;
         pos     = '0;
         if (!stall) begin
            valid_d = src_valid;
            ch_d    = src_ch;
            for (int j = 0; j < NODES; j++) begin
               pos       = IW'(4 * j) | IW'(idx);
               data_d[j] = src[pos];
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            valid_q <= 1'b0;
            ch_q    <= '0;
            for (int j = 0; j < NODES; j++) begin
               data_q[j] <= '0;
            end
         end else begin
            valid_q <= valid_d;
            ch_q    <= ch_d;
            data_q  <= data_d;
         end
      end
   end

   assign out_valid = g_st[STAGES-1].valid_q;
   assign out_data  = g_st[STAGES-1].data_q[0];
   assign out_ch    = g_st[STAGES-1].ch_q;

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Directed bench for mux_tree_pipe: default N=8 instance plus N=2, N=5 and
// N=64/WIDTH=1 corner instances sharing clock and reset.
module tb_mux_tree_pipe;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   // Default instance N=8, WIDTH=8
   logic [63:0] in_data;
   logic        in_valid, in_ready, mode, scan_clr, out_valid, out_ready;
   logic [2:0]  sel, out_ch;
   logic [7:0]  out_data;

   mux_tree_pipe #(.WIDTH(8), .N(8)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .mode(mode), .sel(sel), .scan_clr(scan_clr),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
      .out_ready(out_ready)
   );

   // N=2, WIDTH=8
   logic [15:0] d2;
   logic        v2, r2, ov2;
   logic [0:0]  s2, c2;
   logic [7:0]  o2;

   mux_tree_pipe #(.WIDTH(8), .N(2)) dut2 (
      .clk(clk), .rst(rst), .in_data(d2), .in_valid(v2), .in_ready(r2),
      .mode(1'b0), .sel(s2), .scan_clr(1'b0), .out_data(o2), .out_ch(c2),
      .out_valid(ov2), .out_ready(1'b1)
   );

   // N=5, WIDTH=8
   logic [39:0] d5;
   logic        v5, r5, ov5;
   logic [2:0]  s5, c5;
   logic [7:0]  o5;

   mux_tree_pipe #(.WIDTH(8), .N(5)) dut5 (
      .clk(clk), .rst(rst), .in_data(d5), .in_valid(v5), .in_ready(r5),
      .mode(1'b0), .sel(s5), .scan_clr(1'b0), .out_data(o5), .out_ch(c5),
      .out_valid(ov5), .out_ready(1'b1)
   );

   // N=64, WIDTH=1
   logic [63:0] d64;
   logic        v64, r64, ov64;
   logic [5:0]  s64, c64;
   logic [0:0]  o64;

   mux_tree_pipe #(.WIDTH(1), .N(64)) dut64 (
      .clk(clk), .rst(rst), .in_data(d64), .in_valid(v64), .in_ready(r64),
      .mode(1'b0), .sel(s64), .scan_clr(1'b0), .out_data(o64), .out_ch(c64),
      .out_valid(ov64), .out_ready(1'b1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   int bv [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
   int bm [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
   int bs [8] = '{6, 0, 0, 0, 1, 0, 0, 0};
   int bc [8] = '{6, 0, 4, 0, 1, 0, 5, 0};

   initial begin
      clk = 1'b0;
      checks = 0;
      errors = 0;
      rst = 1'b1;
      in_valid = 1'b0; mode = 1'b0; sel = '0; scan_clr = 1'b0; out_ready = 1'b1;
      v2 = 1'b0; s2 = '0; v5 = 1'b0; s5 = '0; v64 = 1'b0; s64 = '0;
      for (int k = 0; k < 8; k++) in_data[k*8 +: 8] = 8'hA0 + 8'(k);
      d2  = {8'h5B, 8'h3C};
      for (int k = 0; k < 5; k++) d5[k*8 +: 8] = 8'h10 + 8'(k);
      d64 = 64'hF0E1_D2C3_B4A5_9687;

      step(); step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_ch", 64'(out_ch), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_scan", 64'(dut.scan_q), 64'd0);
      rst = 1'b0;

      // Manual sweep sel=0..7 back-to-back
      for (int i = 0; i <= 8; i++) begin
         in_valid = (i < 8);
         sel = 3'(i);
         step();
         if (i == 0) chk("sweep_lat", 64'(out_valid), 64'd0);
         else begin
            chk("sweep_valid", 64'(out_valid), 64'd1);
            chk("sweep_data", 64'(out_data), 64'(8'hA0 + 8'(i - 1)));
            chk("sweep_ch", 64'(out_ch), 64'(i - 1));
         end
      end
      step();
      chk("sweep_drain", 64'(out_valid), 64'd0);

      // Auto-scan 10 beats with wrap
      mode = 1'b1;
      for (int i = 0; i <= 10; i++) begin
         in_valid = (i < 10);
         step();
         if (i > 0) begin
            chk("scan_ch", 64'(out_ch), 64'((i - 1) % 8));
            chk("scan_data", 64'(out_data), 64'(8'hA0 + 8'((i - 1) % 8)));
         end
      end
      in_valid = 1'b1; scan_clr = 1'b1;
      step();
      scan_clr = 1'b0;
      step();
      chk("clr_beat_ch", 64'(out_ch), 64'd2);
      in_valid = 1'b0;
      step();
      chk("after_clr_ch", 64'(out_ch), 64'd0);
      chk("after_clr_valid", 64'(out_valid), 64'd1);
      step();
      chk("after_clr_drain", 64'(out_valid), 64'd0);

      // Backpressure: 5 stalled cycles
      in_valid = 1'b1;
      step(); step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_data", 64'(out_data), 64'hA1);
         chk("bp_ch", 64'(out_ch), 64'd1);
         chk("bp_scan", 64'(dut.scan_q), 64'd3);
      end
      out_ready = 1'b1;
      step();
      chk("bp_rel_ch", 64'(out_ch), 64'd2);
      in_valid = 1'b0;
      step();
      chk("bp_rel_ch2", 64'(out_ch), 64'd3);
      step();
      chk("bp_drain", 64'(out_valid), 64'd0);
      chk("bp_scan_end", 64'(dut.scan_q), 64'd4);

      // Bubbles with mode toggling
      for (int i = 0; i < 8; i++) begin
         in_valid = bv[i][0];
         mode = bm[i][0];
         sel = 3'(bs[i]);
         step();
         if (i > 0) begin
            chk("bub_valid", 64'(out_valid), 64'(bv[i-1]));
            if (bv[i-1] != 0) chk("bub_ch", 64'(out_ch), 64'(bc[i-1]));
         end
      end
      chk("bub_scan", 64'(dut.scan_q), 64'd6);

      // Reset while two beats are stalled in flight
      mode = 1'b0; in_valid = 1'b1; sel = 3'd3;
      step();
      sel = 3'd5;
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      step();
      chk("pre_rst_stall", 64'(in_ready), 64'd0);
      rst = 1'b1;
      step();
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_ch", 64'(out_ch), 64'd0);
      chk("mid_rst_scan", 64'(dut.scan_q), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_idle", 64'(out_valid), 64'd0);
      end

      // N=2: single-stage latency
      v2 = 1'b1; s2 = 1'b1;
      step();
      chk("n2_valid", 64'(ov2), 64'd1);
      chk("n2_data1", 64'(o2), 64'h5B);
      chk("n2_ch1", 64'(c2), 64'd1);
      s2 = 1'b0;
      step();
      chk("n2_data0", 64'(o2), 64'h3C);
      chk("n2_ch0", 64'(c2), 64'd0);
      v2 = 1'b0;
      step();
      chk("n2_drain", 64'(ov2), 64'd0);

      // N=5: sel=7 clamps to channel 4
      v5 = 1'b1; s5 = 3'd7;
      step();
      s5 = 3'd2;
      step();
      chk("n5_clamp_ch", 64'(c5), 64'd4);
      chk("n5_clamp_data", 64'(o5), 64'h14);
      v5 = 1'b0;
      step();
      chk("n5_ch2", 64'(c5), 64'd2);
      chk("n5_data2", 64'(o5), 64'h12);
      step();
      chk("n5_drain", 64'(ov5), 64'd0);

      // N=64, WIDTH=1: 3-stage sweep
      for (int i = 0; i < 66; i++) begin
         v64 = (i < 64);
         s64 = 6'(i);
         step();
         if (i < 2) chk("n64_lat", 64'(ov64), 64'd0);
         else begin
            chk("n64_ch", 64'(c64), 64'(i - 2));
            chk("n64_data", 64'(o64), 64'(d64[i - 2]));
         end
      end
      step();
      step();
      chk("n64_drain", 64'(ov64), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
